conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Layer sequencer for the 3x3 conv engine.
- Per input channel: loads the 80-bit weight/bias word, streams the row windows into the PE array group by group, then commands the output-feature-map send and waits for the AXI-Stream frame end.
- Sits between the param memory, the 5-row line buffer and the conv engine.
- Owns the engine's params-valid, pe-valid, row-done, current-channel and send-flag inputs.

Parameters:
IMG_W, 48, output columns per row group (column beats per group)
IMG_H, 48, output rows per channel; must be a multiple of ROWS_PER_PASS
ROWS_PER_PASS, 3, output rows produced per row group
PARAM_W, 80, param word width (72 weight + 8 bias)
TLAST_TIMEOUT, 65535, max cycles in WAIT_TLAST before error

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_start  in  1  start layer; sampled only in IDLE
i_abort  in  1  synchronous abort, any state
i_num_ic  in  6  input channels to process; sampled on accepted start
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at layer end
o_err  out  1  sticky tlast-timeout flag; cleared by accepted start or reset
o_param_rd_en  out  1  param memory read strobe
o_param_addr  out  6  param memory address (= current ic)
i_param_data  in  PARAM_W  param memory read data, 1-cycle read latency
o_params  out  PARAM_W  registered param word to engine
o_params_valid  out  1  one-cycle load strobe to engine
o_current_ic  out  6  channel index under process
i_rows_ready  in  1  line buffer holds 5 valid rows for current group
o_row_fetch_en  out  1  advance line-buffer column read
o_pe_valid  out  1  row data valid to PE array
o_img_row_done  out  1  one-cycle end-of-group pulse
o_send_flg  out  1  one-cycle send command to engine
i_axis_tvalid/i_axis_tready/i_axis_tlast  in  1 each  monitored engine output stream

Behaviour:
- Reset / abort: all outputs 0, ic = col = group = 0, state IDLE, effective next edge.
  - Abort suppresses o_done.
  - Abort does not clear o_err.
- States: IDLE, PRM_RD, PRM_LD, WAIT_ROWS, STREAM, ROW_DONE, SEND, WAIT_TLAST, DONE.
- IDLE:
  - i_start with i_num_ic != 0: latch num_ic, ic = 0, clear o_err, go to PRM_RD.
  - i_start with i_num_ic == 0: go to DONE (o_done next cycle, no engine activity).
  - i_start while busy is ignored.
- PRM_RD (1 cycle): o_param_rd_en = 1, o_param_addr = ic.
- PRM_LD (1 cycle): o_params <= i_param_data; o_params_valid high next cycle for 1 cycle; go to WAIT_ROWS.
- WAIT_ROWS: hold until i_rows_ready = 1, then go to STREAM.
- STREAM:
  - o_row_fetch_en = i_rows_ready (combinational).
  - col increments on each fetch.
  - i_rows_ready low stalls: no fetch, col held.
  - Fetch at col = IMG_W-1: col <= 0, go to ROW_DONE.
- o_pe_valid = o_row_fetch_en delayed 1 cycle (registered). Exactly IMG_W pe_valid pulses per group.
- ROW_DONE (1 cycle):
  - o_img_row_done high in the cycle after the last o_pe_valid of the group.
  - group increments; group = IMG_H/ROWS_PER_PASS - 1 → group <= 0, go to SEND; else go to WAIT_ROWS.
- SEND: o_send_flg high 1 cycle; go to WAIT_TLAST; timeout counter = 0.
- WAIT_TLAST:
  - On i_axis_tvalid & i_axis_tready & i_axis_tlast: if ic = num_ic-1 go to DONE, else ic++ and go to PRM_RD.
  - Counter reaches TLAST_TIMEOUT: set o_err, go to DONE.
- DONE: o_done high 1 cycle; go to IDLE.
- Simultaneous events:
  - Abort has priority over every transition.
  - tlast and timeout in the same cycle: tlast wins, o_err not set.
- o_current_ic = ic register; updates only on the ic increment or reset/abort.

Test Plan:
- num_ic=2, rows_ready always 1 → per ic: 1 params_valid, 16 groups × 48 pe_valid, 16 img_row_done, 1 send_flg; after 2nd tlast o_done; o_current_ic goes 0 then 1.
- rows_ready low for 5 cycles at col 20 → no fetch while low; pe_valid still totals exactly 48; img_row_done one cycle after the 48th pe_valid.
- Param memory returns 0xA5..01 for ic=1 → o_params equals it when o_params_valid pulses; rd_en→params_valid gap is 2 cycles.
- i_num_ic=0 start → o_done pulse within 2 cycles; no param_rd_en, pe_valid or send_flg.
- TLAST_TIMEOUT=100, tlast never arrives → o_err=1 at cycle 100 of WAIT_TLAST, then o_done; next start clears o_err.
- Abort mid-STREAM at group 7 → next cycle all outputs 0, state IDLE, no o_done; restart runs from ic=0, group 0.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: layer sequencer for the 3x3 conv engine.
// For each input channel it reads and loads the weight/bias word, streams
// IMG_H/ROWS_PER_PASS row groups of IMG_W column beats into the PE array,
// commands the output-feature-map send and waits for the stream's tlast.
//
// Ports
//   clk, rstn               clock, synchronous active-low reset
//   i_start, i_num_ic       layer start (IDLE only) and channel count
//   i_abort                 synchronous abort, any state
//   o_busy, o_done, o_err   status: busy, end-of-layer pulse, sticky timeout
//   o_param_rd_en/addr      param memory read (1-cycle latency on i_param_data)
//   o_params, o_params_valid  registered param word and its load strobe
//   o_current_ic            channel index under process
//   i_rows_ready            line buffer has the rows for the current group
//   o_row_fetch_en          combinational column advance to the line buffer
//   o_pe_valid              fetch delayed one cycle, data valid to the PEs
//   o_img_row_done          end-of-group pulse
//   o_send_flg              send command to the engine
//   i_axis_*                monitored engine output stream
module conv_seq_ctrl #(
  parameter int unsigned IMG_W         = 48,
  parameter int unsigned IMG_H         = 48,
  parameter int unsigned ROWS_PER_PASS = 3,
  parameter int unsigned PARAM_W       = 80,
  parameter int unsigned TLAST_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [5:0]         i_num_ic,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_param_rd_en,
  output logic [5:0]         o_param_addr,
  input  logic [PARAM_W-1:0] i_param_data,
  output logic [PARAM_W-1:0] o_params,
  output logic               o_params_valid,
  output logic [5:0]         o_current_ic,
  input  logic               i_rows_ready,
  output logic               o_row_fetch_en,
  output logic               o_pe_valid,
  output logic               o_img_row_done,
  output logic               o_send_flg,
  input  logic               i_axis_tvalid,
  input  logic               i_axis_tready,
  input  logic               i_axis_tlast
);

  localparam int unsigned IC_W   = 6;
  localparam int unsigned GROUPS = IMG_H / ROWS_PER_PASS;
  localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned TMO_W  = $clog2(TLAST_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRM_RD, S_PRM_LD, S_WAIT_ROWS, S_STREAM,
    S_ROW_DONE, S_SEND, S_WAIT_TLAST, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IC_W-1:0]    ic_q, ic_d;
  logic [IC_W-1:0]    num_ic_q, num_ic_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [GRP_W-1:0]   group_q, group_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [PARAM_W-1:0] params_q, params_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               pvalid_q, pvalid_d;
  logic               pe_valid_q, pe_valid_d;
  logic               row_done_q, row_done_d;
  logic               send_q, send_d;
  logic               fetch_c;
  logic               tlast_hs_c;

  assign fetch_c    = (state_q == S_STREAM) && i_rows_ready;
  assign tlast_hs_c = i_axis_tvalid && i_axis_tready && i_axis_tlast;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    ic_d       = ic_q;
    num_ic_d   = num_ic_q;
    col_d      = col_q;
    group_d    = group_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    params_d   = params_q;
    pvalid_d   = 1'b0;
    pe_valid_d = fetch_c;
    row_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          err_d = 1'b0;
          if (i_num_ic != '0) begin
            num_ic_d = i_num_ic;
            ic_d     = '0;
            state_d  = S_PRM_RD;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_PRM_RD: state_d = S_PRM_LD;
      S_PRM_LD: begin
        params_d = i_param_data;
        pvalid_d = 1'b1;
        state_d  = S_WAIT_ROWS;
      end
      S_WAIT_ROWS: begin
        if (i_rows_ready) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (fetch_c) begin
          if (col_q == COL_W'(IMG_W - 1)) begin
            col_d   = '0;
            state_d = S_ROW_DONE;
          end else begin
            col_d   = col_q + COL_W'(1);
          end
        end
      end
      S_ROW_DONE: begin
        // Pulse lands one cycle after the group's final pe_valid
        row_done_d = 1'b1;
        if (group_q == GRP_W'(GROUPS - 1)) begin
          group_d = '0;
          state_d = S_SEND;
        end else begin
          group_d = group_q + GRP_W'(1);
          state_d = S_WAIT_ROWS;
        end
      end
      S_SEND: begin
        tmo_d   = '0;
        state_d = S_WAIT_TLAST;
      end
      S_WAIT_TLAST: begin
        // tlast beats a coincident timeout
        if (tlast_hs_c) begin
          if (ic_q == IC_W'(num_ic_q - IC_W'(1))) begin
            state_d = S_DONE;
          end else begin
            ic_d    = ic_q + IC_W'(1);
            state_d = S_PRM_RD;
          end
        end else if (tmo_q == TMO_W'(TLAST_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition but leaves the error flag alone
    if (i_abort) begin
      state_d    = S_IDLE;
      ic_d       = '0;
      num_ic_d   = '0;
      col_d      = '0;
      group_d    = '0;
      tmo_d      = '0;
      err_d      = err_q;
      params_d   = '0;
      pvalid_d   = 1'b0;
      pe_valid_d = 1'b0;
      row_done_d = 1'b0;
    end

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_PRM_RD);
    send_d  = (state_d == S_SEND);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ic_q       <= '0;
      num_ic_q   <= '0;
      col_q      <= '0;
      group_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      params_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      pvalid_q   <= 1'b0;
      pe_valid_q <= 1'b0;
      row_done_q <= 1'b0;
      send_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ic_q       <= ic_d;
      num_ic_q   <= num_ic_d;
      col_q      <= col_d;
      group_q    <= group_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      params_q   <= params_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      pvalid_q   <= pvalid_d;
      pe_valid_q <= pe_valid_d;
      row_done_q <= row_done_d;
      send_q     <= send_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_param_rd_en  = rd_en_q;
  assign o_param_addr   = ic_q;
  assign o_params       = params_q;
  assign o_params_valid = pvalid_q;
  assign o_current_ic   = ic_q;
  assign o_row_fetch_en = fetch_c;
  assign o_pe_valid     = pe_valid_q;
  assign o_img_row_done = row_done_q;
  assign o_send_flg     = send_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl.
// Expected param words / channel indices are queued at layer start and
// popped on each o_params_valid; per-group beat counts and per-run event
// totals are compared against bench-side constants.
module tb_conv_seq_ctrl;

  localparam int unsigned IMG_W   = 48;
  localparam int unsigned IMG_H   = 48;
  localparam int unsigned RPP     = 3;
  localparam int unsigned PW      = 80;
  localparam int unsigned TMO     = 100;
  localparam int unsigned GROUPS  = IMG_H / RPP;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [5:0]    i_num_ic = '0;
  logic          o_busy, o_done, o_err, o_param_rd_en;
  logic [5:0]    o_param_addr;
  logic [PW-1:0] i_param_data = '0;
  logic [PW-1:0] o_params;
  logic          o_params_valid;
  logic [5:0]    o_current_ic;
  logic          i_rows_ready = 1'b1;
  logic          o_row_fetch_en, o_pe_valid, o_img_row_done, o_send_flg;
  logic          i_axis_tvalid = 1'b0;
  logic          i_axis_tready = 1'b0;
  logic          i_axis_tlast = 1'b0;

  conv_seq_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ROWS_PER_PASS(RPP),
    .PARAM_W(PW), .TLAST_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_abort(i_abort),
    .i_num_ic(i_num_ic), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_param_rd_en(o_param_rd_en), .o_param_addr(o_param_addr),
    .i_param_data(i_param_data), .o_params(o_params),
    .o_params_valid(o_params_valid), .o_current_ic(o_current_ic),
    .i_rows_ready(i_rows_ready), .o_row_fetch_en(o_row_fetch_en),
    .o_pe_valid(o_pe_valid), .o_img_row_done(o_img_row_done),
    .o_send_flg(o_send_flg), .i_axis_tvalid(i_axis_tvalid),
    .i_axis_tready(i_axis_tready), .i_axis_tlast(i_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] params;
    logic [5:0]    ic;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] mem [64];
  int            n_checks = 0;
  int            n_errs   = 0;
  int            cyc = 0, rd_cyc = 0, send_cyc = 0, done_cyc = 0;
  int            cnt_rd = 0, cnt_pv = 0, cnt_pe = 0, cnt_rowd = 0;
  int            cnt_send = 0, cnt_done = 0;
  int            grp_fetch = 0, grp_pe = 0;
  bit            prev_pe = 1'b0;
  bit            tlast_en = 1'b1;
  int            s_rd, s_pv, s_pe, s_rowd, s_send, s_done;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Param memory model, one-cycle read latency
  always @(posedge clk) if (o_param_rd_en) i_param_data <= mem[o_param_addr];

  // Output monitor / scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!o_busy) begin
        grp_fetch = 0;
        grp_pe    = 0;
      end
      if (o_param_rd_en) begin
        cnt_rd++;
        rd_cyc = cyc;
      end
      if (o_params_valid) begin
        cnt_pv++;
        chk("rd_to_pvalid_gap", PW'(cyc - rd_cyc), PW'(2));
        if (exp_q.size() == 0) begin
          chk("params_unexpected", PW'(1), PW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("params", o_params, e.params);
          chk("current_ic", PW'(o_current_ic), PW'(e.ic));
        end
      end
      if (o_row_fetch_en) grp_fetch = (grp_fetch == IMG_W - 1) ? 0 : grp_fetch + 1;
      if (o_pe_valid) begin
        cnt_pe++;
        grp_pe++;
      end
      if (o_img_row_done) begin
        cnt_rowd++;
        chk("group_pe_count", PW'(grp_pe), PW'(IMG_W));
        chk("row_done_after_pe", PW'(prev_pe), PW'(1));
        grp_pe = 0;
      end
      if (o_send_flg) begin
        cnt_send++;
        send_cyc = cyc;
      end
      if (o_done) begin
        cnt_done++;
        done_cyc = cyc;
      end
      prev_pe = o_pe_valid;
    end
  end

  // Stream responder: a non-last beat, then the tlast beat
  initial begin
    forever begin
      @(negedge clk);
      if (o_send_flg && tlast_en) begin
        repeat (2) @(posedge clk);
        #1 i_axis_tvalid = 1'b1; i_axis_tready = 1'b1; i_axis_tlast = 1'b0;
        @(posedge clk);
        #1 i_axis_tlast = 1'b1;
        @(posedge clk);
        #1 i_axis_tvalid = 1'b0; i_axis_tready = 1'b0; i_axis_tlast = 1'b0;
      end
    end
  end

  task automatic start_layer(input int n);
    @(posedge clk);
    #1 i_start = 1'b1; i_num_ic = 6'(n);
    for (int i = 0; i < n; i++) exp_q.push_back('{params: mem[i], ic: 6'(i)});
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int base;
    base = cnt_done;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (cnt_done != base) return;
    end
    chk(tag, PW'(0), PW'(1));
  endtask

  task automatic snap();
    s_rd = cnt_rd; s_pv = cnt_pv; s_pe = cnt_pe;
    s_rowd = cnt_rowd; s_send = cnt_send; s_done = cnt_done;
  endtask

  task automatic check_run(input string tag, input int rd, input int pv, input int pe,
                           input int rowd, input int send, input int done);
    chk({tag, "_rd_en"},    PW'(cnt_rd - s_rd),     PW'(rd));
    chk({tag, "_pvalid"},   PW'(cnt_pv - s_pv),     PW'(pv));
    chk({tag, "_pe_valid"}, PW'(cnt_pe - s_pe),     PW'(pe));
    chk({tag, "_row_done"}, PW'(cnt_rowd - s_rowd), PW'(rowd));
    chk({tag, "_send"},     PW'(cnt_send - s_send), PW'(send));
    chk({tag, "_done"},     PW'(cnt_done - s_done), PW'(done));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) mem[i] = (PW'(16'hC0DE) << 64) | PW'(i * 7 + 3);
    mem[1] = 80'hA5_1122_3344_5566_7788_01;

    // Reset
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_busy", PW'(o_busy), PW'(0));
    chk("rst_done", PW'(o_done), PW'(0));
    chk("rst_err",  PW'(o_err),  PW'(0));
    chk("rst_ic",   PW'(o_current_ic), PW'(0));
    chk("rst_params", o_params, PW'(0));

    // Two channels, with a 5-cycle rows_ready stall at col 20 of the first group
    snap();
    start_layer(2);
    for (k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (grp_fetch == 20) break;
    end
    if (k >= 2000) chk("stall_wait_timeout", PW'(0), PW'(1));
    i_rows_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_no_fetch", PW'(o_row_fetch_en), PW'(0));
      @(posedge clk);
    end
    #1 i_rows_ready = 1'b1;
    wait_done(5000, "two_ic_done_timeout");
    check_run("two_ic", 2, 2, 2 * GROUPS * IMG_W, 2 * GROUPS, 2, 1);
    chk("two_ic_err", PW'(o_err), PW'(0));
    chk("two_ic_queue_empty", PW'(exp_q.size()), PW'(0));

    // Tlast never arrives: timeout sets the error flag then finishes
    tlast_en = 1'b0;
    snap();
    start_layer(1);
    wait_done(5000, "timeout_done_timeout");
    chk("timeout_err", PW'(o_err), PW'(1));
    chk("timeout_latency", PW'(done_cyc - send_cyc), PW'(TMO + 1));
    check_run("timeout", 1, 1, GROUPS * IMG_W, GROUPS, 1, 1);
    tlast_en = 1'b1;
    repeat (3) @(posedge clk);
    chk("err_sticky_idle", PW'(o_err), PW'(1));

    // Zero-channel start: immediate done, no engine activity, error cleared
    snap();
    start_layer(0);
    wait_done(2, "zero_ic_done_timeout");
    repeat (2) @(posedge clk);
    check_run("zero_ic", 0, 0, 0, 0, 0, 1);
    chk("zero_ic_err_cleared", PW'(o_err), PW'(0));

    // Abort mid-stream in group 7, then restart from scratch
    snap();
    start_layer(2);
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if ((cnt_rowd - s_rowd) == 7 && grp_fetch >= 10) break;
    end
    if (k >= 3000) chk("abort_wait_timeout", PW'(0), PW'(1));
    i_abort = 1'b1;
    @(posedge clk);
    #1 i_abort = 1'b0;
    @(negedge clk);
    chk("abort_busy",     PW'(o_busy),         PW'(0));
    chk("abort_done",     PW'(o_done),         PW'(0));
    chk("abort_pe_valid", PW'(o_pe_valid),     PW'(0));
    chk("abort_fetch",    PW'(o_row_fetch_en), PW'(0));
    chk("abort_row_done", PW'(o_img_row_done), PW'(0));
    chk("abort_send",     PW'(o_send_flg),     PW'(0));
    chk("abort_rd_en",    PW'(o_param_rd_en),  PW'(0));
    chk("abort_pvalid",   PW'(o_params_valid), PW'(0));
    chk("abort_params",   o_params,            PW'(0));
    chk("abort_ic",       PW'(o_current_ic),   PW'(0));
    @(posedge clk);
    exp_q.delete();
    repeat (20) @(posedge clk);
    chk("abort_no_done", PW'(cnt_done - s_done), PW'(0));
    chk("abort_row_done_count", PW'(cnt_rowd - s_rowd), PW'(7));

    snap();
    start_layer(1);
    wait_done(5000, "restart_done_timeout");
    check_run("restart", 1, 1, GROUPS * IMG_W, GROUPS, 1, 1);
    chk("restart_queue_empty", PW'(exp_q.size()), PW'(0));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
